wts_channel_register: RTL



---
 rtl/wts_channel_register.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/wts_channel_register.sv
// CPU-facing register file for the wave table sound generator: per-channel frequency,
// volume and enable, with readback, phase-reset pulses and a slot-multiplexed parameter stream.
module wts_channel_register #(
    parameter int NUM_CH = 5,
    parameter int FREQ_W = 12,
    parameter int VOL_W  = 4
) (
    input  logic              nreset,
    input  logic              clk,
    input  logic              wrreq,
    input  logic              rdreq,
    input  logic [7:0]        address,
    input  logic [7:0]        wrdata,
    output logic [7:0]        rddata,
    output logic              rdack,
    input  logic              slot_next,
    output logic [2:0]        slot,
    output logic [FREQ_W-1:0] slot_frequency,
    output logic [VOL_W-1:0]  slot_volume,
    output logic              slot_enable,
    output logic [NUM_CH-1:0] phase_reset
);
    localparam int         HI_W     = FREQ_W - 8;
    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);
    localparam logic [2:0] LAST_CH  = 3'(NUM_CH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_STAGED = 1'b1} stage_st_t;

    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [FREQ_W-1:0] freq_d [NUM_CH];
    logic [VOL_W-1:0]  vol_q  [NUM_CH];
    logic [VOL_W-1:0]  vol_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [1:0]        mode_q, mode_d;
    logic [NUM_CH-1:0] pr_q, pr_d;
    stage_st_t         st_q, st_d;
    logic [2:0]        stage_ch_q, stage_ch_d;
    logic [7:0]        stage_data_q, stage_data_d;
    logic [7:0]        rddata_q;
    logic              rdack_q;
    logic [2:0]        cnt_q, slot_q;
    logic [FREQ_W-1:0] slot_freq_q;
    logic [VOL_W-1:0]  slot_vol_q;
    logic              slot_en_q;
    logic [7:0]        rd_s;
    logic              commit_s;

    logic [2:0] fch_s, vch_s;
    logic       is_flo_s, is_fhi_s, is_vol_s, is_mode_s, is_en_s, is_pr_s;

    assign fch_s     = address[3:1];
    assign vch_s     = address[2:0];
    assign is_flo_s  = (address[7:4] == 4'h0) && !address[0] && ({1'b0, fch_s} < NUM_CH_L);
    assign is_fhi_s  = (address[7:4] == 4'h0) &&  address[0] && ({1'b0, fch_s} < NUM_CH_L);
    assign is_vol_s  = (address[7:3] == 5'b00100) && ({1'b0, vch_s} < NUM_CH_L);
    assign is_mode_s = (address == 8'h2E);
    assign is_en_s   = (address == 8'h2F);
    assign is_pr_s   = (address == 8'h30);

    // Staging FSM next state: a locked low byte waits here for its high byte
    always_comb begin
        st_d         = st_q;
        stage_ch_d   = stage_ch_q;
        stage_data_d = stage_data_q;
        if (wrreq && is_mode_s && !wrdata[1]) begin
            st_d = ST_IDLE;
        end else if (wrreq && is_flo_s && mode_q[1]) begin
            st_d         = ST_STAGED;
            stage_ch_d   = fch_s;
            stage_data_d = wrdata;
        end else if (commit_s) begin
            st_d = ST_IDLE;
        end else begin
            st_d = st_q;
        end
    end

    // Staging FSM output: high-byte write to the staged channel also commits the low byte
    always_comb begin
        commit_s = 1'b0;
        if ((st_q == ST_STAGED) && (stage_ch_q == fch_s)) begin
            commit_s = wrreq && is_fhi_s;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Register write decode and phase-reset trigger
    always_comb begin
        freq_d = freq_q;
        vol_d  = vol_q;
        en_d   = en_q;
        mode_d = mode_q;
        pr_d   = '0;
        if (wrreq) begin
            if (is_flo_s && !mode_q[1]) begin
                freq_d[fch_s][7:0] = wrdata;
            end else if (is_fhi_s) begin
                freq_d[fch_s][FREQ_W-1:8] = wrdata[HI_W-1:0];
                if (commit_s) begin
                    freq_d[fch_s][7:0] = stage_data_q;
                end else begin
                    freq_d[fch_s][7:0] = freq_q[fch_s][7:0];
                end
            end else if (is_vol_s) begin
                vol_d[vch_s] = wrdata[VOL_W-1:0];
            end else if (is_mode_s) begin
                mode_d = wrdata[1:0];
            end else if (is_en_s) begin
                en_d = wrdata[NUM_CH-1:0];
            end else if (is_pr_s) begin
                pr_d = wrdata[NUM_CH-1:0];
            end else begin
                mode_d = mode_q;
            end
            if ((is_flo_s || is_fhi_s) && mode_q[0]) begin
                pr_d[fch_s] = 1'b1;
            end else begin
                pr_d = pr_d;
            end
        end else begin
            pr_d = '0;
        end
    end

    // Readback mux; the staged byte is never visible
    always_comb begin
        rd_s = 8'h00;
        if (is_flo_s) begin
            rd_s = freq_q[fch_s][7:0];
        end else if (is_fhi_s) begin
            rd_s[HI_W-1:0] = freq_q[fch_s][FREQ_W-1:8];
        end else if (is_vol_s) begin
            rd_s[VOL_W-1:0] = vol_q[vch_s];
        end else if (is_mode_s) begin
            rd_s[1:0] = mode_q;
        end else if (is_en_s) begin
            rd_s[NUM_CH-1:0] = en_q;
        end else begin
            rd_s = 8'h00;
        end
    end

    // Register file, staging state and read port
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freq_q[i] <= '0;
                vol_q[i]  <= '0;
            end
            en_q         <= '0;
            mode_q       <= 2'b00;
            pr_q         <= '0;
            st_q         <= ST_IDLE;
            stage_ch_q   <= 3'd0;
            stage_data_q <= 8'h00;
            rddata_q     <= 8'h00;
            rdack_q      <= 1'b0;
        end else begin
            freq_q       <= freq_d;
            vol_q        <= vol_d;
            en_q         <= en_d;
            mode_q       <= mode_d;
            pr_q         <= pr_d;
            st_q         <= st_d;
            stage_ch_q   <= stage_ch_d;
            stage_data_q <= stage_data_d;
            rdack_q      <= rdreq;
            rddata_q     <= rdreq ? rd_s : rddata_q;
        end
    end

    // Slot counter and the registered parameter stream it selects
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q       <= 3'd0;
            slot_q      <= 3'd0;
            slot_freq_q <= '0;
            slot_vol_q  <= '0;
            slot_en_q   <= 1'b0;
        end else begin
            if (slot_next) begin
                cnt_q <= (cnt_q == LAST_CH) ? 3'd0 : cnt_q + 3'd1;
            end else begin
                cnt_q <= cnt_q;
            end
            slot_q      <= cnt_q;
            slot_freq_q <= freq_q[cnt_q];
            slot_vol_q  <= vol_q[cnt_q];
            slot_en_q   <= en_q[cnt_q];
        end
    end

    assign rddata         = rddata_q;
    assign rdack          = rdack_q;
    assign slot           = slot_q;
    assign slot_frequency = slot_freq_q;
    assign slot_volume    = slot_vol_q;
    assign slot_enable    = slot_en_q;
    assign phase_reset    = pr_q;

endmodule
